// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// The signed variant is selected elsewhere by SHIFT_ADD_MULT_SIGNED_EN.
package shift_add_mult_pkg;

    localparam int         WIDTH     = 16;
    localparam logic [4:0] LAST_ITER = 5'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// 16-bit ripple-carry adder; the multiplier uses it once per clock.
module adder
    import shift_add_mult_pkg::*;
(
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]  = in1[i] ^ in2[i] ^ c[i];
        assign c[i+1]  = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
    end

    assign co = c[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for the multiplier: IDLE -> RUN (16 iterations) -> DONE.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// ready never depends combinationally on valid, and a producer holds data while valid waits.
module mult_ctrl
    import shift_add_mult_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    input  logic   out_ready,
    output logic   in_ready,
    output logic   out_valid,
    output logic   load,
    output logic   step,
    output logic   last,
    output state_t state_dbg
);

    state_t     state;
    logic [4:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= RUN;
                        cnt      <= 5'd0;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 5'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // in_ready is a registered copy of (state == IDLE), so load needs no state decode.
    assign load      = in_valid & in_ready;
    assign step      = (state == RUN);
    assign last      = step && (cnt == LAST_ITER);
    assign state_dbg = state;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential 16x16->32 shift-and-add multiplier driving one ripple adder per clock.
// Define SHIFT_ADD_MULT_SIGNED_EN for two's-complement operands and product.
module shift_add_mult
    import shift_add_mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0] m, p, q;
    logic [WIDTH-1:0] x, sum;
    logic             cin, co, ext;
    logic             load, step, last;
    state_t           state_dbg;
    logic             ctrl_unused;

    mult_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .load      (load),
        .step      (step),
        .last      (last),
        .state_dbg (state_dbg)
    );

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    // The multiplier's sign bit has weight -2^15, so the final partial product is subtracted.
    assign x   = q[0] ? (last ? ~m : m) : '0;
    assign cin = last & q[0];
    assign ext = p[WIDTH-1] ^ x[WIDTH-1] ^ co;
`else
    assign x   = q[0] ? m : '0;
    assign cin = 1'b0;
    assign ext = co;
`endif

    assign ctrl_unused = ^{last, state_dbg};

    adder u_adder (
        .in1 (p),
        .in2 (x),
        .cin (cin),
        .sum (sum),
        .co  (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
            p <= '0;
            q <= '0;
        end else if (load) begin
            m <= in_a;
            p <= '0;
            q <= in_b;
        end else if (step) begin
            p <= {ext, sum[WIDTH-1:1]};
            q <= {sum[0], q[WIDTH-1:1]};
        end
    end

    assign product = {p, q};

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed + randomized bench for shift_add_mult with an arithmetic reference model.
module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] product;

    int          checks_total = 0;
    int          checks_passed = 0;
    logic [31:0] exp_q[$];

    shift_add_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        logic signed [31:0] sa, sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        return sa * sb;
`else
        logic [31:0] ua, ub;
        ua = {16'd0, a};
        ub = {16'd0, b};
        return ua * ub;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(ref_mult(a, b));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 32'd16);
        if (exp_q.size() > 0) check(tag, product, exp_q.pop_front());
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] p0;
        logic        bp_bad;
        logic [15:0] a_arr[4];
        logic [15:0] b_arr[4];
        int          acc_cyc[$];
        int          k, results;
        logic        iv, ov;
        logic [31:0] pr;

        // reset state
        rst_n = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_product", product, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // basic
        start_op(16'd3, 16'd5);
        wait_done("basic_3x5");
        check("basic_const", product, 32'h0000_000F);
        drain();

        // extremes
        start_op(16'hFFFF, 16'hFFFF);
        wait_done("ffff_x_ffff");
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        check("ffff_const_signed", product, 32'h0000_0001);
`else
        check("ffff_const", product, 32'hFFFE_0001);
`endif
        drain();
        start_op(16'h0000, 16'h1234);
        wait_done("zero_x_1234");
        check("zero_const", product, 32'd0);
        drain();

`ifdef SHIFT_ADD_MULT_SIGNED_EN
        start_op(16'h8000, 16'h8000);
        wait_done("min_x_min");
        check("min_const", product, 32'h4000_0000);
        drain();
        start_op(16'h0003, 16'hFFFB);
        wait_done("3_x_m5");
        check("3_x_m5_const", product, 32'hFFFF_FFF1);
        drain();
`endif

        // backpressure with ignored in_valid pulses
        start_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        wait_done("bp_op");
        p0 = product;
        bp_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 16'($urandom_range(0, 65535));
            in_b     = 16'($urandom_range(0, 65535));
            tick();
            if (product !== p0 || out_valid !== 1'b1 || in_ready !== 1'b0) bp_bad = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_product_stable", product, p0);
        check("bp_flags_held", {31'd0, bp_bad}, 32'd0);
        drain();

        // reset mid-RUN at cnt == 7
        start_op(16'h1234, 16'h5678);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_product", product, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_op(16'd7, 16'd9);
        wait_done("after_rst_7x9");
        check("after_rst_const", product, 32'd63);
        drain();

        // random single operations
        for (int i = 0; i < 6; i++) begin
            start_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            wait_done("random_op");
            drain();
        end

        // back-to-back: in_valid held, out_ready held
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = 16'($urandom_range(0, 65535));
            b_arr[i] = 16'($urandom_range(0, 65535));
        end
        k = 0;
        results = 0;
        out_ready = 1'b1;
        in_a = a_arr[0];
        in_b = b_arr[0];
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 120 && results < 4; cyc++) begin
            iv = in_ready & in_valid;
            ov = out_valid;
            pr = product;
            tick();
            if (iv) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(ref_mult(a_arr[k], b_arr[k]));
                k++;
                if (k < 4) begin
                    in_a = a_arr[k];
                    in_b = b_arr[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (ov) begin
                if (exp_q.size() > 0) check("b2b_product", pr, exp_q.pop_front());
                results++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", results, 32'd4);
        check("b2b_accepts", acc_cyc.size(), 32'd4);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 32'd18);
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
